// File: rtl/booth_mult_param.sv
// Iterative Booth multiplier with radix 4 or 8 recoding and a start/done handshake.
// Per-operation signed or unsigned operands; product is held until the next accepted start.
module booth_mult_param #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned RADIX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     dataM,
  input  logic [WIDTH-1:0]     dataQ,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned K    = (RADIX == 8) ? 3 : 2;
  localparam int unsigned QW   = ((WIDTH + 1 + K - 1) / K) * K;
  localparam int unsigned ITER = QW / K;
  localparam int unsigned AW   = WIDTH + K + 1;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned SW   = AW + QW + 1;

  if (RADIX != 4 && RADIX != 8) begin : g_bad_radix
    $error("booth_mult_param: RADIX must be 4 or 8");
  end
  if (WIDTH < 4) begin : g_bad_width
    $error("booth_mult_param: WIDTH must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  state_t         state;
  logic [AW-1:0]  a;
  logic [AW-1:0]  m;
  logic [AW-1:0]  m3;
  logic [QW-1:0]  q;
  logic           qm1;
  logic [CW-1:0]  cnt;

  logic [AW-1:0]  m_ext;
  logic [QW-1:0]  q_ext;
  logic [3:0]     dig;
  logic           neg;
  logic [2:0]     mag;
  logic [AW-1:0]  mult;
  logic [AW-1:0]  addend;
  logic [AW-1:0]  a_sum;
  logic signed [SW-1:0] cat;
  logic signed [SW-1:0] sh;

  // Operand extension happens at accept time, so sgn needs no register of its own
  assign m_ext = {{(AW - WIDTH){sgn & dataM[WIDTH-1]}}, dataM};
  assign q_ext = {{(QW - WIDTH){sgn & dataQ[WIDTH-1]}}, dataQ};

  // One Booth step: recode digit, add the selected multiple, arithmetic shift by K
  always_comb begin
    dig = 4'(q[K-2:0]) + 4'(qm1) - 4'(4'(q[K-1]) << (K - 1));
    neg = dig[3];
    mag = 3'(neg ? 4'(-dig) : dig);
    case (mag)
      3'd0:    mult = '0;
      3'd1:    mult = m;
      3'd2:    mult = m << 1;
      3'd3:    mult = m3;
      3'd4:    mult = m << 2;
      default: mult = '0;
    endcase
    addend = neg ? AW'(-mult) : mult;
    a_sum  = a + addend;
    cat    = {a_sum, q, qm1};
    sh     = cat >>> K;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a       <= '0;
      m       <= '0;
      m3      <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= m_ext;
            q     <= q_ext;
            a     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          m3    <= m + (m << 1);
          state <= CALC;
        end
        CALC: begin
          a   <= sh[SW-1 -: AW];
          q   <= sh[QW:1];
          qm1 <= sh[0];
          if (cnt == CW'(ITER - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= sh[2*WIDTH:1];
            state   <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_param.sv
// Self-checking bench for booth_mult_param: default (15-bit radix-8) and 8-bit radix-4 instances
// checked against a plain-arithmetic multiply model.
module tb_booth_mult_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, sgn_a, busy_a, done_a;
  logic [14:0] m_a, q_a;
  logic [29:0] prod_a;

  logic        rst_b, start_b, sgn_b, busy_b, done_b;
  logic [7:0]  m_b, q_b;
  logic [15:0] prod_b;

  int n_tests = 0;
  int n_fail  = 0;

  booth_mult_param #(.WIDTH(15), .RADIX(8)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .sgn(sgn_a), .dataM(m_a), .dataQ(q_a),
    .busy(busy_a), .done(done_a), .product(prod_a)
  );

  booth_mult_param #(.WIDTH(8), .RADIX(4)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .sgn(sgn_b), .dataM(m_b), .dataQ(q_b),
    .busy(busy_b), .done(done_b), .product(prod_b)
  );

  // Reference: exact integer product of the operands interpreted at width w
  function automatic longint ref_mul(input bit s, input int w, input longint m, input longint q);
    longint lim = longint'(1) << w;
    longint mm  = m & (lim - 1);
    longint qq  = q & (lim - 1);
    if (s && mm >= (lim >> 1)) mm -= lim;
    if (s && qq >= (lim >> 1)) qq -= lim;
    return mm * qq;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_a(input bit s, input logic [14:0] m, input logic [14:0] q,
                      output logic [29:0] p, output int lat, output int bad);
    sgn_a = s; m_a = m; q_a = q; start_a = 1'b1;
    tick();
    start_a = 1'b0; sgn_a = 1'($urandom); m_a = 15'($urandom); q_a = 15'($urandom);
    p = '0; lat = -1; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done_a) begin
        lat = c; p = prod_a;
        if (busy_a) bad++;
        break;
      end
      if (!busy_a) bad++;
      tick();
    end
  endtask

  task automatic do_b(input bit s, input logic [7:0] m, input logic [7:0] q,
                      output logic [15:0] p, output int lat);
    sgn_b = s; m_b = m; q_b = q; start_b = 1'b1;
    tick();
    start_b = 1'b0; sgn_b = 1'($urandom); m_b = 8'($urandom); q_b = 8'($urandom);
    p = '0; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done_b) begin lat = c; p = prod_b; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    sgn_a = 1'b0; sgn_b = 1'b0; m_a = '0; q_a = '0; m_b = '0; q_b = '0;
    tick(); tick();
    n_tests += 6;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset busy_a: got %b expected 0", busy_a); end
    if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset done_a: got %b expected 0", done_a); end
    if (prod_a !== 30'h0) begin n_fail++; $display("FAIL reset prod_a: got %h expected 0", prod_a); end
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset busy_b: got %b expected 0", busy_b); end
    if (done_b !== 1'b0) begin n_fail++; $display("FAIL reset done_b: got %b expected 0", done_b); end
    if (prod_b !== 16'h0) begin n_fail++; $display("FAIL reset prod_b: got %h expected 0", prod_b); end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    bit          vs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [14:0] vm[4] = '{15'h7FFD, 15'h7FFF, 15'h7FFF, 15'h4000};
    logic [14:0] vq[4] = '{15'd12345, 15'h7FFF, 15'h7FFF, 15'h4000};
    logic [29:0] vp[4] = '{30'h3FFF6F55, 30'h3FFF0001, 30'h0000_0001, 30'h1000_0000};
    logic [29:0] p;
    logic [15:0] pb;
    int lat, bad;
    for (int i = 0; i < 4; i++) begin
      do_a(vs[i], vm[i], vq[i], p, lat, bad);
      n_tests += 4;
      if (p !== vp[i]) begin n_fail++; $display("FAIL vector%0d product: got %h expected %h", i, p, vp[i]); end
      if (lat != 8) begin n_fail++; $display("FAIL vector%0d latency: got %0d expected 8", i, lat); end
      if (bad != 0) begin n_fail++; $display("FAIL vector%0d busy profile: %0d bad cycles expected 0", i, bad); end
      tick();
      if (done_a !== 1'b0 || prod_a !== vp[i]) begin
        n_fail++;
        $display("FAIL vector%0d after done: done=%b prod=%h expected done=0 prod=%h", i, done_a, prod_a, vp[i]);
      end
    end
    do_b(1'b1, 8'h80, 8'h7F, pb, lat);
    n_tests += 2;
    if (pb !== 16'hC080) begin n_fail++; $display("FAIL r4 vector product: got %h expected c080", pb); end
    if (lat != 7) begin n_fail++; $display("FAIL r4 vector latency: got %0d expected 7", lat); end
    tick();
  endtask

  task automatic test_random_a();
    logic [29:0] p, exp;
    logic [14:0] m, q;
    bit s;
    int lat, bad;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      m = 15'($urandom); q = 15'($urandom);
      if (i % 10 == 0) m = 15'h4000;
      if (i % 10 == 1) q = 15'h7FFF;
      exp = 30'(ref_mul(s, 15, longint'(m), longint'(q)));
      do_a(s, m, q, p, lat, bad);
      n_tests += 2;
      if (p !== exp) begin n_fail++; $display("FAIL rand_a s=%0d m=%h q=%h: got %h expected %h", s, m, q, p, exp); end
      if (lat != 8 || bad != 0) begin n_fail++; $display("FAIL rand_a timing: latency %0d bad %0d expected 8 and 0", lat, bad); end
      tick();
    end
  endtask

  task automatic test_sweep_b();
    logic [7:0]  qs[6];
    logic [15:0] p, exp;
    int lat;
    for (int mi = 0; mi < 256; mi++) begin
      qs = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'($urandom)};
      for (int qi = 0; qi < 6; qi++) begin
        for (int s = 0; s < 2; s++) begin
          exp = 16'(ref_mul(1'(s), 8, longint'(mi), longint'(qs[qi])));
          do_b(1'(s), 8'(mi), qs[qi], p, lat);
          n_tests++;
          if (p !== exp || lat != 7) begin
            n_fail++;
            $display("FAIL sweep_b s=%0d m=%h q=%h: got %h lat %0d expected %h lat 7", s, mi, qs[qi], p, lat, exp);
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [14:0] m1, q1;
    logic [29:0] p, exp;
    int lat, extra;
    m1 = 15'($urandom); q1 = 15'($urandom);
    exp = 30'(ref_mul(1'b1, 15, longint'(m1), longint'(q1)));
    sgn_a = 1'b1; m_a = m1; q_a = q1; start_a = 1'b1;
    tick();
    lat = -1; extra = 0; p = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2 || c == 8) begin
        start_a = 1'b1; sgn_a = 1'b0; m_a = ~m1; q_a = q1 ^ 15'h1234;
      end else begin
        start_a = 1'b0;
      end
      if (done_a && lat < 0) begin lat = c; p = prod_a; end
      else if (c > 8 && (done_a || busy_a)) extra++;
      tick();
    end
    start_a = 1'b0;
    n_tests += 3;
    if (p !== exp) begin n_fail++; $display("FAIL ignore product: got %h expected %h", p, exp); end
    if (lat != 8) begin n_fail++; $display("FAIL ignore latency: got %0d expected 8", lat); end
    if (extra != 0) begin n_fail++; $display("FAIL ignore later activity: %0d cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] m, q;
    logic [29:0] p, exp;
    int lat, bad;
    for (int i = 0; i < 3; i++) begin
      m = 15'($urandom); q = 15'($urandom);
      exp = 30'(ref_mul(1'b0, 15, longint'(m), longint'(q)));
      do_a(1'b0, m, q, p, lat, bad);
      if (i == 0) begin tick(); continue; end
      n_tests += 2;
      if (p !== exp) begin n_fail++; $display("FAIL b2b%0d product: got %h expected %h", i, p, exp); end
      if (lat != 8) begin n_fail++; $display("FAIL b2b%0d latency: got %0d expected 8", i, lat); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] p;
    int lat, bad, act;
    do_a(1'b0, 15'd3, 15'd5, p, lat, bad);
    tick();
    sgn_a = 1'b1; m_a = 15'h1ABC; q_a = 15'h2DEF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_tests += 4;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b expected 0", busy_a); end
    if (done_a !== 1'b0) begin n_fail++; $display("FAIL midreset done: got %b expected 0", done_a); end
    if (prod_a !== 30'h0) begin n_fail++; $display("FAIL midreset product: got %h expected 0", prod_a); end
    act = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_a || busy_a) act++;
      tick();
    end
    if (act != 0) begin n_fail++; $display("FAIL midreset aftermath: %0d active cycles expected 0", act); end
    do_a(1'b0, 15'd5, 15'd7, p, lat, bad);
    n_tests += 2;
    if (p !== 30'd35) begin n_fail++; $display("FAIL midreset fresh product: got %0d expected 35", p); end
    if (lat != 8) begin n_fail++; $display("FAIL midreset fresh latency: got %0d expected 8", lat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random_a();
    test_sweep_b();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
